uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_core slot (cs/read/write/reg_addr/wr_data/rd_data) between NUM_REQ byte producers.
//  Programs CTRL_REG after reset and on request. Round-robin grants producers.
//  Polls STATUS_REG until the TX FIFO is not full, then writes the granted byte to WRITE_REG.
//  Sits between the SoC's internal producers and the uart_core slot port; acts as the sole slot master.
// PARAMETERS
//  NUM_REQ    4             number of byte producers (2..8)
//  DATA_BITS  8             byte width; zero-extended onto wr_data[31:0]
//  CTRL_INIT  32'h0000_028A CTRL_REG value after reset (dvsr=650 -> 9600 baud @100 MHz, 8N1)
// PORTS
//  clk        in   1                  system clock
//  reset      in   1                  synchronous, active-high reset
//  cfg_wr     in   1                  pulse: reprogram CTRL_REG with cfg_data
//  cfg_data   in   32                 new CTRL_REG value, sampled when cfg_wr=1
//  req_valid  in   NUM_REQ            per-producer byte valid
//  req_data   in   NUM_REQ*DATA_BITS  producer i byte at [i*DATA_BITS +: DATA_BITS]
//  req_ready  out  NUM_REQ            one-hot pulse: byte consumed this cycle
//  grant_id   out  $clog2(NUM_REQ)    index of current/last granted producer
//  busy       out  1                  1 in any state except S_IDLE
//  cs         out  1                  slot chip select
//  read       out  1                  slot read strobe
//  write      out  1                  slot write strobe
//  reg_addr   out  5                  slot register address
//  wr_data    out  32                 slot write data
//  rd_data    in   32                 slot read data, valid combinationally in the same cycle as cs&read
// BEHAVIOUR
//  - Reset: while reset=1, every output is 0. State<=S_CFG, ctrl_shadow<=CTRL_INIT, cfg_pend<=0,
//    last_grant<=NUM_REQ-1 (producer 0 wins first).
//  - Slot outputs are decoded from registered state: S_IDLE drives all zero.
//  - S_CFG (1 cycle): cs=1, write=1, reg_addr=CTRL_REG, wr_data=ctrl_shadow. Clear cfg_pend. -> S_IDLE.
//  - S_IDLE: if cfg_pend -> S_CFG (config beats requests).
//    Else if |req_valid: rr_arbiter picks the first valid index after last_grant, with wrap-around.
//    Latch it into grant_id -> S_POLL. Else stay.
//  - S_POLL: cs=1, read=1, reg_addr=STATUS_REG.
//    If req_valid[grant_id]=0 (protocol violation) -> S_IDLE, no write, last_grant unchanged.
//    Else if rd_data[ST_TX_FULL]=0 -> S_WRITE. Else stay and re-poll every cycle, with no timeout.
//  - S_WRITE (1 cycle): cs=1, write=1, reg_addr=WRITE_REG, wr_data={'0, req_data[grant_id]}.
//    req_ready[grant_id]=1 (only this cycle). last_grant<=grant_id. -> S_IDLE.
//  - Handshake: transfer occurs when req_valid&req_ready. The producer holds data stable from valid until ready.
//  - Latency: minimum 3 cycles per byte (IDLE,POLL,WRITE). Back-to-back grants are possible every 3 cycles.
//  - cfg_wr: accepted in any state. Sets cfg_pend and loads ctrl_shadow; last cfg_wr wins.
//    An in-flight POLL/WRITE is never aborted; S_CFG follows the next S_IDLE.
//  - cfg_wr in the same cycle as the reset release: ignored (reset has priority).
//  - Reset mid-POLL/WRITE: the write is abandoned, no req_ready, and S_CFG is the first cycle after release.
//  - cs is never asserted with both read and write set.
// STRUCTURE
//  - uart_pkg (shared): uart_reg_e {CTRL_REG=5'd0, STATUS_REG=5'd1, READ_REG=5'd2, WRITE_REG=5'd3}.
//  - uart_pkg status bits: ST_PARITY_ERR=0, ST_FRAME_ERR=1, ST_OVERRUN=2, ST_RX_EMPTY=3, ST_TX_FULL=4.
//  - uart_pkg CTRL masks: PARITY_EN=32'h800, PARITY_EVEN=32'h1000, STOP_1_5=32'h2000, STOP_2=32'h4000,
//    DATA_7=32'h8000, DVSR_MASK=32'h7FF.
//  - Local enum: arb_state_e {S_CFG, S_IDLE, S_POLL, S_WRITE}.
//  - Sub-module rr_arbiter #(N): inputs req[N] and last[$clog2(N)]; outputs gnt_id and any. Combinational.
// TESTING
//  1. Reset release, no requests -> cycle 1: cs=1,write=1,reg_addr=0,wr_data=0x28A; then cs=0 steady.
//  2. req_valid[0]=1, data 0x33, rd_data[4]=0 -> POLL 1 cycle.
//     Then WRITE: reg_addr=3, wr_data=0x33, req_ready=4'b0001.
//  3. All 4 valid with 0xA0..0xA3, held -> WRITEs in order 0,1,2,3. The 5th grant is 0.
//     Each producer gets exactly one req_ready pulse per byte.
//  4. rd_data[4]=1 for 20 cycles -> 20 STATUS reads, write=0, req_ready=0.
//     Bit cleared -> WRITE the next cycle.
//  5. cfg_wr with 0x0000_A28A during POLL -> the pending byte is written first.
//     Then the CTRL_REG write of 0xA28A happens before the next POLL.
//  6. reset pulse mid-POLL -> all outputs 0, no WRITE_REG access, and CTRL_REG=CTRL_INIT written on release.
//     Loopback with uart_core (FIFO_DEPTH=2): bytes 0xBD,0x18 appear on tx in order.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared uart_core register map, status bits, control masks and arbiter state encoding.
package uart_tx_arbiter_pkg;

    typedef enum logic [4:0] {
        CTRL_REG   = 5'd0,
        STATUS_REG = 5'd1,
        READ_REG   = 5'd2,
        WRITE_REG  = 5'd3
    } uart_reg_e;

    localparam int ST_PARITY_ERR = 0;
    localparam int ST_FRAME_ERR  = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_FULL    = 4;

    localparam logic [31:0] PARITY_EN   = 32'h0000_0800;
    localparam logic [31:0] PARITY_EVEN = 32'h0000_1000;
    localparam logic [31:0] STOP_1_5    = 32'h0000_2000;
    localparam logic [31:0] STOP_2      = 32'h0000_4000;
    localparam logic [31:0] DATA_7      = 32'h0000_8000;
    localparam logic [31:0] DVSR_MASK   = 32'h0000_07FF;

    typedef enum logic [1:0] {
        S_CFG   = 2'd0,
        S_IDLE  = 2'd1,
        S_POLL  = 2'd2,
        S_WRITE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after index 'last', wrapping around.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    int idx_s;

    // Scan from farthest to nearest offset so the nearest valid request overwrites the rest.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx_s  = 0;
        for (int k = N; k >= 1; k--) begin
            idx_s  = (int'(last) + k) % N;
            gnt_id = req[idx_s] ? IDX_W'(idx_s) : gnt_id;
            any    = any | req[idx_s];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Sole master of a uart_core slot: programs CTRL_REG, round-robins byte producers and
// writes each granted byte to WRITE_REG once STATUS_REG reports room in the TX FIFO.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter int          DATA_BITS = 8,
    parameter logic [31:0] CTRL_INIT = 32'h0000_028A
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_wr,
    input  logic [31:0]                    cfg_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           cs,
    output logic                           read,
    output logic                           write,
    output logic [4:0]                     reg_addr,
    output logic [31:0]                    wr_data,
    input  logic [31:0]                    rd_data
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_e           state_r;
    logic [31:0]          ctrl_shadow_r;
    logic                 cfg_pend_r;
    logic [IDX_W-1:0]     last_grant_r;
    logic [IDX_W-1:0]     grant_id_r;

    logic [IDX_W-1:0]     arb_gnt_s;
    logic                 arb_any_s;
    logic [DATA_BITS-1:0] sel_data_s;
    logic                 tx_full_s;
    logic                 unused_rd_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (req_valid),
        .last   (last_grant_r),
        .gnt_id (arb_gnt_s),
        .any    (arb_any_s)
    );

    assign sel_data_s  = req_data[grant_id_r*DATA_BITS +: DATA_BITS];
    assign tx_full_s   = rd_data[ST_TX_FULL];
    assign unused_rd_s = ^{rd_data[31:ST_TX_FULL+1], rd_data[ST_TX_FULL-1:0]};

    // Arbitration FSM plus config shadow; a config request never aborts a started transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_CFG;
            ctrl_shadow_r <= CTRL_INIT;
            cfg_pend_r    <= 1'b0;
            last_grant_r  <= LAST_INIT;
            grant_id_r    <= '0;
        end else begin
            if (cfg_wr) begin
                ctrl_shadow_r <= cfg_data;
            end
            cfg_pend_r <= (state_r == S_CFG) ? cfg_wr : (cfg_pend_r | cfg_wr);
            case (state_r)
                S_CFG: begin
                    state_r <= S_IDLE;
                end
                S_IDLE: begin
                    if (cfg_pend_r) begin
                        state_r <= S_CFG;
                    end else if (arb_any_s) begin
                        grant_id_r <= arb_gnt_s;
                        state_r    <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (!req_valid[grant_id_r]) begin
                        state_r <= S_IDLE;
                    end else if (!tx_full_s) begin
                        state_r <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    last_grant_r <= grant_id_r;
                    state_r      <= S_IDLE;
                end
                default: begin
                    state_r <= S_CFG;
                end
            endcase
        end
    end

    // Slot and handshake outputs decoded from the registered state, forced low during reset.
    always_comb begin
        cs        = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        reg_addr  = 5'd0;
        wr_data   = 32'd0;
        req_ready = '0;
        busy      = 1'b0;
        grant_id  = '0;
        if (reset) begin
            busy = 1'b0;
        end else begin
            busy     = (state_r != S_IDLE);
            grant_id = grant_id_r;
            case (state_r)
                S_CFG: begin
                    cs       = 1'b1;
                    write    = 1'b1;
                    reg_addr = CTRL_REG;
                    wr_data  = ctrl_shadow_r;
                end
                S_POLL: begin
                    cs       = 1'b1;
                    read     = 1'b1;
                    reg_addr = STATUS_REG;
                end
                S_WRITE: begin
                    cs        = 1'b1;
                    write     = 1'b1;
                    reg_addr  = WRITE_REG;
                    wr_data   = 32'(sel_data_s);
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
                end
                default: begin
                    cs = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a round-robin / config reference model.
module tb_uart_tx_arbiter;

    localparam int          N         = 4;
    localparam logic [31:0] INIT_CTRL = 32'h0000_028A;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [31:0] cfg_data;
    logic [N-1:0] req_valid;
    logic [7:0]  pdata [N];
    logic [N*8-1:0] req_data;
    logic [N-1:0] req_ready;
    logic [1:0]  grant_id;
    logic        busy, cs, read, write;
    logic [4:0]  reg_addr;
    logic [31:0] wr_data, rd_data;
    logic        rd_full;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(8), .CTRL_INIT(INIT_CTRL)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy), .cs(cs), .read(read), .write(write),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid producer after the last served one, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Scoreboard state
    logic [7:0]  exp_q [N][$];
    logic [31:0] ctrl_exp;
    bit          ctrl_pend;
    bit          pend_before;
    int          last_wr;
    bit          prev_reset, prev_poll, prev_poll_ok;
    logic [N-1:0] prev_valid;
    int          n_bytes = 0;
    bit          gen_on = 1'b0;

    // Monitor: compares every observed slot access against the reference model.
    always @(negedge clk) begin
        int p, e;
        if (reset) begin
            check({req_ready, grant_id, busy, cs, read, write, reg_addr} == '0 && wr_data == 32'd0,
                  "reset_zero", {cs, read, write, busy}, 32'd0);
            ctrl_exp     = INIT_CTRL;
            ctrl_pend    = 1'b1;
            last_wr      = N - 1;
            prev_reset   = 1'b1;
            prev_poll    = 1'b0;
            prev_poll_ok = 1'b0;
            pend_before  = 1'b1;
        end else begin
            check(!(read && write), "rw_excl", {read, write}, 32'd0);
            check(busy == cs, "busy_cs", busy, cs);
            if (prev_reset)
                check(cs && write && reg_addr == 5'd0, "cfg_after_reset", {cs, write, reg_addr}, 32'h60);
            if (cs && write && reg_addr == 5'd0) begin
                check(ctrl_pend, "ctrl_pending", 32'(ctrl_pend), 32'd1);
                check(wr_data == ctrl_exp, "ctrl_data", wr_data, ctrl_exp);
                ctrl_pend = 1'b0;
            end
            if (cs && write && reg_addr == 5'd3) begin
                p = int'(grant_id);
                check(prev_poll_ok, "write_after_notfull", 32'(prev_poll_ok), 32'd1);
                check(req_ready == (4'b0001 << p), "ready_onehot", req_ready, 4'b0001 << p);
                check(exp_q[p].size() > 0, "unexpected_byte", p, 32'hFF);
                if (exp_q[p].size() > 0) begin
                    e = exp_q[p].pop_front();
                    check(wr_data == 32'(e), "byte_data", wr_data, e);
                end
                last_wr = p;
                n_bytes++;
            end else begin
                check(req_ready == '0, "ready_idle", req_ready, 32'd0);
            end
            if (prev_poll_ok)
                check(cs && write && reg_addr == 5'd3, "write_follows_poll", {cs, write, reg_addr}, 32'h63);
            if (cs && read) begin
                check(reg_addr == 5'd1, "poll_addr", reg_addr, 32'd1);
                if (!prev_poll) begin
                    e = rr_pick(prev_valid, last_wr);
                    check(int'(grant_id) == e, "rr_grant", grant_id, e);
                    check(!pend_before, "cfg_before_grant", 32'(pend_before), 32'd0);
                end
            end
            prev_poll    = cs && read;
            prev_poll_ok = cs && read && !rd_data[4] && req_valid[grant_id];
            pend_before  = ctrl_pend;
            if (cfg_wr) begin
                ctrl_exp  = cfg_data;
                ctrl_pend = 1'b1;
            end
            prev_reset = 1'b0;
        end
        prev_valid = req_valid;
    end

    // Producers: hold each byte until consumed, then maybe offer a fresh random one.
    initial begin
        logic [N-1:0] rdy;
        logic [7:0]   b;
        req_valid = '0;
        for (int i = 0; i < N; i++) pdata[i] = 8'h00;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && gen_on && $urandom_range(0, 3) == 0) begin
                    b = 8'($urandom);
                    exp_q[i].push_back(b);
                    pdata[i] = b;
                    req_valid[i] = 1'b1;
                end
            end
        end
    end

    assign rd_data = {27'h5A5A5A5, rd_full, 4'hF};

    task automatic wait_poll();
        int n;
        n = 0;
        @(negedge clk);
        while (!(cs && read) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(cs && read, "poll_seen", {cs, read}, 32'd3);
    endtask

    initial begin
        int polls;
        int n;
        reset = 1'b1; cfg_wr = 1'b0; cfg_data = 32'd0; rd_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check(cs && write && reg_addr == 5'd0 && wr_data == INIT_CTRL, "init_cfg", wr_data, INIT_CTRL);
        repeat (4) begin
            @(negedge clk);
            check(!cs, "idle_cs", cs, 32'd0);
        end

        // Free-running traffic with an always-ready FIFO
        @(posedge clk); #1 gen_on = 1'b1;
        repeat (200) @(posedge clk);

        // TX FIFO full for 20 polls, then released
        #1 rd_full = 1'b1;
        wait_poll();
        polls = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (cs && read && !write && req_ready == '0) polls++;
        end
        check(polls == 20, "full_polls", polls, 32'd20);
        @(posedge clk); #1 rd_full = 1'b0;
        @(negedge clk);
        check(cs && read, "poll_notfull", {cs, read}, 32'd3);
        @(negedge clk);
        check(write && reg_addr == 5'd3, "write_after_release", {write, reg_addr}, 32'h23);

        // Config request during a poll: byte first, then CTRL_REG
        @(posedge clk); #1 rd_full = 1'b1;
        wait_poll();
        @(posedge clk); #1 cfg_wr = 1'b1; cfg_data = 32'h0000_A28A;
        @(posedge clk); #1 cfg_wr = 1'b0; rd_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(write && reg_addr == 5'd3, "byte_before_cfg", {write, reg_addr}, 32'h23);
        @(negedge clk);
        @(negedge clk);
        check(cs && write && reg_addr == 5'd0 && wr_data == 32'h0000_A28A, "cfg_after_byte", wr_data, 32'h0000_A28A);

        // Reset pulse mid-poll
        @(posedge clk); #1 rd_full = 1'b1;
        wait_poll();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; rd_full = 1'b0;
        @(negedge clk);
        check(cs && write && reg_addr == 5'd0 && wr_data == INIT_CTRL, "cfg_after_midreset", wr_data, INIT_CTRL);

        // Randomized phase: FIFO backpressure, config writes and occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            rd_full  = ($urandom_range(0, 2) == 0);
            cfg_wr   = ($urandom_range(0, 49) == 0);
            cfg_data = $urandom;
            reset    = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1 reset = 1'b0; cfg_wr = 1'b0; rd_full = 1'b0; gen_on = 1'b0;

        // Drain
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(n < 500, "drain_timeout", n, 32'd500);
        check(!ctrl_pend, "ctrl_drained", 32'(ctrl_pend), 32'd0);
        check(n_bytes > 50, "bytes_moved", n_bytes, 32'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
